// File: rtl/stopwatch_ndigit.sv
// stopwatch_ndigit: N-digit BCD stopwatch (m:ss.t) on a multiplexed 7-seg display.
// Lap/hold display compiled in only when STOPWATCH_LAP_EN is defined.
module stopwatch_ndigit #(
  parameter int NDIGITS     = 4,
  parameter int TICK_DIV    = 10_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               clr,
  input  logic               lap,
  output logic [NDIGITS-1:0] an,
  output logic [6:0]         sseg,
  output logic               dp,
  output logic               ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(NDIGITS);

  typedef logic [NDIGITS-1:0][3:0] bcd_t;

  logic [PW-1:0] presc;
  logic          tick;
  bcd_t          cnt;
  bcd_t          nxt;
  logic          wrap;
  bcd_t          disp;
  logic [RW-1:0] rcnt;
  logic [SW-1:0] sel;
  logic [3:0]    dval;

  function automatic logic [3:0] dmax(input int i);
    return (i == 2) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign tick = go && (presc == PW'(TICK_DIV - 1));

  // prescaler: advances only while go, so a pause keeps the partial tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (go) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // BCD increment with ripple carry; carry out of the top digit means wrap
  always_comb begin
    logic carry;
    nxt   = cnt;
    carry = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (carry) begin
        if (cnt[i] == dmax(i)) begin
          nxt[i] = 4'd0;
        end else begin
          nxt[i] = cnt[i] + 4'd1;
          carry  = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  // live count and sticky overflow; clear beats a coincident tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (tick) begin
      cnt <= nxt;
      if (wrap) ovf <= 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  typedef enum logic {LIVE, HELD} state_t;

  state_t state;
  state_t state_n;
  bcd_t   hold;

  // display-source state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LIVE;
    else     state <= state_n;
  end

  // lap toggles the source; clear always lands in LIVE
  always_comb begin
    state_n = state;
    if (clr) begin
      state_n = LIVE;
    end else if (lap) begin
      state_n = (state == LIVE) ? HELD : LIVE;
    end
  end

  // snapshot the count on entry to HELD; kept on return to LIVE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (clr) begin
      hold <= '0;
    end else if (lap && state == LIVE) begin
      hold <= cnt;
    end
  end

  assign disp = (state == HELD) ? hold : cnt;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign disp       = cnt;
`endif

  // refresh timer: each digit stays selected for REFRESH_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
      sel  <= '0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      sel  <= (sel == SW'(NDIGITS - 1)) ? '0 : sel + SW'(1);
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  assign dval = disp[sel];

  // registered display drive for the selected digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an   <= '1;
      sseg <= 7'h7F;
      dp   <= 1'b1;
    end else begin
      an   <= ~(NDIGITS'(1) << sel);
      sseg <= seg7(dval);
      dp   <= (sel != SW'(1));
    end
  end

endmodule

// File: doc/stopwatch_ndigit.md
STOPWATCH_NDIGIT -- requirements
Module: stopwatch_ndigit

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, number of BCD digits (legal range 4..8).
REQ-002 SHALL have parameter TICK_DIV, default 10_000_000, clk cycles per 0.1 s count tick (legal value >= 2).
REQ-003 SHALL have parameter REFRESH_DIV, default 100_000, clk cycles each digit is driven (legal value >= 2).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port go, input, 1 bit, level: counting is enabled while high.
REQ-007 SHALL have port clr, input, 1 bit, synchronous clear, sampled on each rising edge.
REQ-008 SHALL have port lap, input, 1 bit, single-cycle lap pulse.
REQ-009 SHALL have port an, output, NDIGITS bits: active-low digit enables.
REQ-010 SHALL have port sseg, output, 7 bits, active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag, set when the count wraps past its maximum.

Function
REQ-013 SHALL derive a one-cycle tick from a prescaler that counts 0..TICK_DIV-1 while go=1; the tick fires at TICK_DIV-1, then the prescaler returns to 0.
REQ-014 SHALL hold the prescaler value while go=0, so a pause does not lose a partial tick.
REQ-015 SHALL increment a BCD count on each tick; the incremented value is visible on the cycle after the tick.
REQ-016 SHALL use these digit moduli: digit0 (tenths) 0-9, digit1 (seconds) 0-9, digit2 (tens of seconds) 0-5, digit3 and above 0-9, with the carry rippling within the same cycle.
REQ-017 SHALL wrap the count from all-maximum (for example 9:59.9 at NDIGITS=4) to all-zero and set ovf on that same edge.
REQ-018 SHALL implement the display-source FSM states LIVE and HELD; reset state is LIVE.
REQ-019 SHALL, on lap=1 in LIVE, copy the count into a hold register and go to HELD; counting continues unaffected.
REQ-020 SHALL, on lap=1 in HELD, return to LIVE; the hold register keeps its value.
REQ-021 SHALL, on clr=1, zero the count, the prescaler, the hold register and ovf, and force LIVE; clr takes priority over a tick and over lap in the same cycle.
REQ-022 SHALL show the hold register in HELD and the live count in LIVE.
REQ-023 SHALL multiplex digits with a refresh counter 0..REFRESH_DIV-1; at REFRESH_DIV-1 the selected digit advances by one and wraps from NDIGITS-1 to 0.
REQ-024 SHALL register an, sseg and dp; exactly one an bit is low, matching the selected digit, one cycle after selection.
REQ-025 SHALL decode 0-9 to standard active-low patterns (for example 0=7'b1000000, 8=7'b0000000).
REQ-026 SHALL drive dp low only while digit1 is selected, and high otherwise.
REQ-027 SHALL NOT blank leading zeros; every digit is always shown.

Reset
REQ-028 SHALL, while rst=1, set count, prescaler, hold register, refresh counter and digit select to 0; FSM to LIVE; ovf=0; an all ones; sseg=7'h7F; dp=1.
REQ-029 SHALL, after rst falls, drive digit 0 on the first rising edge; counting begins only when go=1.
REQ-030 SHALL, on reset mid-count or in HELD, discard all state immediately, without waiting for a clock edge.

Configuration
REQ-031 SHALL compile in the lap function (hold register, HELD state, lap input) when macro STOPWATCH_LAP_EN is defined.
REQ-032 SHALL, without STOPWATCH_LAP_EN, ignore lap, always display the live count, and leave no hold register in the design.

Verification (TICK_DIV=10, REFRESH_DIV=4, NDIGITS=4, STOPWATCH_LAP_EN defined)
REQ-033 SHALL cover: rst for 2 cycles, then go=1 for 100 cycles -> count 00:01.0 (digit1=1, others 0); an cycles 1110, 1101, 1011, 0111, each held 4 cycles.
REQ-034 SHALL cover: go=1 for 35 cycles, then go=0 for 50 cycles, then go=1 for 5 cycles -> count 00:00.4; the prescaler resumes from 5, not 0.
REQ-035 SHALL cover: preload by running to 9:59.9, then 1 more tick -> count 0:00.0, ovf=1; ovf stays 1 until clr.
REQ-036 SHALL cover: at count 00:02.3 pulse lap, run 50 cycles, pulse lap -> display shows 02.3 while the count advances to 02.8; after the second lap the display shows the live 02.8.
REQ-037 SHALL cover: clr and tick in the same cycle while in HELD -> next cycle count 0, FSM in LIVE, ovf=0.
REQ-038 SHALL cover: rst asserted mid-refresh, between clock edges -> an=1111, sseg=7F, dp=1 immediately.
